// File: rtl/systolic_fir_array.sv
// systolic_fir_array
//   NUM_PE-tap systolic FIR with a runtime-loadable weight shift chain,
//   a valid-qualified data path that can stall, a flush input and
//   widened accumulation. Each PE delays x by two registers (xa, xb) and
//   the partial sum by one, so the chain forms a true FIR.
//
//   Define SYSTOLIC_SAT_EN to make every PE's add saturate to the
//   ACC_WIDTH signed range. When it is not defined, the add wraps.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset; also clears the weights
//   in_valid   advance the data path with x_in / y_in this cycle
//   x_in       signed sample, WIDTH bits
//   y_in       signed initial partial sum for PE 0, ACC_WIDTH bits
//   w_load     shift w_data into the weight chain (at the last PE)
//   w_data     signed weight, WIDTH bits
//   flush      clear the data pipeline and fill count; keep the weights
//   out_valid  y_out holds a fully primed result
//   y_out      signed result from the last PE, ACC_WIDTH bits
module systolic_fir_array #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20,
  parameter int NUM_PE    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     x_in,
  input  logic signed [ACC_WIDTH-1:0] y_in,
  input  logic                        w_load,
  input  logic signed [WIDTH-1:0]     w_data,
  input  logic                        flush,
  output logic                        out_valid,
  output logic signed [ACC_WIDTH-1:0] y_out
);

  localparam int FW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(NUM_PE - 1);

  logic signed [WIDTH-1:0]     w     [NUM_PE];
  logic signed [WIDTH-1:0]     xa    [NUM_PE];
  logic signed [WIDTH-1:0]     xb    [NUM_PE];
  logic signed [ACC_WIDTH-1:0] y     [NUM_PE];
  logic signed [ACC_WIDTH-1:0] ynext [NUM_PE];
  logic [FW-1:0]               fill;

  for (genvar k = 0; k < NUM_PE; k++) begin : gen_pe
    logic signed [WIDTH-1:0]       xk;
    logic signed [ACC_WIDTH-1:0]   yk;
    logic signed [2*WIDTH-1:0]     prod;
    logic signed [ACC_WIDTH-1:0]   pext;

    if (k == 0) begin : gen_first
      assign xk = x_in;
      assign yk = y_in;
    end else begin : gen_rest
      assign xk = xb[k-1];
      assign yk = y[k-1];
    end

    assign prod = xk * w[k];
    assign pext = ACC_WIDTH'(prod);

`ifdef SYSTOLIC_SAT_EN
    // One extra bit exposes overflow: the top two bits differ only
    // when the true sum leaves the ACC_WIDTH signed range.
    logic signed [ACC_WIDTH:0] sum;
    assign sum = {yk[ACC_WIDTH-1], yk} + {pext[ACC_WIDTH-1], pext};
    always_comb begin
      ynext[k] = sum[ACC_WIDTH-1:0];
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
        ynext[k] = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`else
    assign ynext[k] = yk + pext;
`endif
  end

  // Weights shift independently of the data path; the MAC above always
  // sees the pre-load weights in a cycle where both happen.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_PE; k++) w[k] <= '0;
    end else if (w_load) begin
      for (int unsigned k = 0; k + 1 < NUM_PE; k++) w[k] <= w[k+1];
      w[NUM_PE-1] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned k = 0; k < NUM_PE; k++) begin
        xa[k] <= '0;
        xb[k] <= '0;
        y[k]  <= '0;
      end
      fill      <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      for (int unsigned k = 0; k < NUM_PE; k++) begin
        xa[k] <= (k == 0) ? x_in : xb[k-1];
        xb[k] <= xa[k];
        y[k]  <= ynext[k];
      end
      out_valid <= (fill == FILL_MAX);
      if (fill != FILL_MAX) fill <= fill + 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign y_out = y[NUM_PE-1];

endmodule

// File: tb/tb_systolic_fir_array.sv
// Testbench for systolic_fir_array: directed test-plan scenarios followed
// by randomized traffic, all checked against a sample-history reference
// model that evaluates the FIR sum directly.
module tb_systolic_fir_array;

  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 16;
  localparam int NUM_PE    = 4;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        in_valid = 1'b0;
  logic signed [WIDTH-1:0]     x_in = '0;
  logic signed [ACC_WIDTH-1:0] y_in = '0;
  logic                        w_load = 1'b0;
  logic signed [WIDTH-1:0]     w_data = '0;
  logic                        flush = 1'b0;
  logic                        out_valid;
  logic signed [ACC_WIDTH-1:0] y_out;

  systolic_fir_array #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .NUM_PE    (NUM_PE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .y_in      (y_in),
    .w_load    (w_load),
    .w_data    (w_data),
    .flush     (flush),
    .out_valid (out_valid),
    .y_out     (y_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: full history of accepted samples, each with the
  // weight vector that was in force when it was accepted.
  typedef longint warr_t [NUM_PE];
  longint xh[$];
  longint yh[$];
  warr_t  wh[$];
  warr_t  wm;
  logic                        exp_valid = 1'b0;
  logic signed [ACC_WIDTH-1:0] exp_y = '0;

  function automatic longint fix(input longint v);
    longint lo, hi;
    logic signed [ACC_WIDTH-1:0] t;
    lo = -(longint'(1) <<< (ACC_WIDTH - 1));
    hi = (longint'(1) <<< (ACC_WIDTH - 1)) - 1;
`ifdef SYSTOLIC_SAT_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    t = v[ACC_WIDTH-1:0];
    return longint'(t);
`endif
  endfunction

  // y_out after sample m: y_in[m-N+1] + sum_k w_k * x[m-N+1-k], where the
  // tap-k weight is the one in force when tap k processed that result.
  function automatic longint model_out();
    longint acc, term;
    int m, base, idx;
    m = xh.size() - 1;
    base = m - NUM_PE + 1;
    acc = (base >= 0) ? yh[base] : 0;
    for (int k = 0; k < NUM_PE; k++) begin
      idx = base - k;
      term = (idx >= 0) ? wh[base + k][k] * xh[idx] : 0;
      acc = fix(acc + term);
    end
    return acc;
  endfunction

  task automatic clear_hist();
    xh.delete();
    yh.delete();
    wh.delete();
  endtask

  task automatic check_out(input string tag);
    checks++;
    assert (out_valid === exp_valid) else begin
      errors++;
      $error("FAIL %s out_valid observed=%0b expected=%0b", tag, out_valid, exp_valid);
    end
    checks++;
    assert (y_out === exp_y) else begin
      errors++;
      $error("FAIL %s y_out observed=%0d expected=%0d", tag, y_out, exp_y);
    end
  endtask

  task automatic check_const(input string tag, input logic signed [ACC_WIDTH-1:0] e, input logic ev);
    checks++;
    assert (y_out === e && out_valid === ev) else begin
      errors++;
      $error("FAIL %s observed y=%0d v=%0b expected y=%0d v=%0b", tag, y_out, out_valid, e, ev);
    end
  endtask

  task automatic step(input string tag, input bit v, input int x, input int yv,
                      input bit wl, input int wd, input bit fl, input bit rs);
    warr_t pre;
    in_valid = v;
    x_in     = WIDTH'(x);
    y_in     = ACC_WIDTH'(yv);
    w_load   = wl;
    w_data   = WIDTH'(wd);
    flush    = fl;
    rst      = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      clear_hist();
      foreach (wm[k]) wm[k] = 0;
      exp_valid = 1'b0;
      exp_y = '0;
    end else begin
      pre = wm;
      if (wl) begin
        for (int k = 0; k < NUM_PE - 1; k++) wm[k] = wm[k+1];
        wm[NUM_PE-1] = longint'(w_data);
      end
      if (fl) begin
        clear_hist();
        exp_valid = 1'b0;
        exp_y = '0;
      end else if (v) begin
        xh.push_back(longint'(x_in));
        yh.push_back(longint'(y_in));
        wh.push_back(pre);
        exp_valid = (xh.size() >= NUM_PE);
        exp_y = ACC_WIDTH'(model_out());
      end else begin
        exp_valid = 1'b0;
      end
    end
    check_out(tag);
  endtask

  task automatic load_w(input int a, input int b, input int c, input int d);
    step("wl", 0, 0, 0, 1, a, 0, 0);
    step("wl", 0, 0, 0, 1, b, 0, 0);
    step("wl", 0, 0, 0, 1, c, 0, 0);
    step("wl", 0, 0, 0, 1, d, 0, 0);
  endtask

  initial begin
    foreach (wm[k]) wm[k] = 0;

    // Reset state
    step("rst", 0, 0, 0, 0, 0, 0, 1);
    step("rst", 0, 0, 0, 0, 0, 0, 1);
    check_const("reset_state", 0, 0);

    // Impulse
    load_w(2, 3, 4, 5);
    for (int i = 0; i < 7; i++) begin
      step("imp", 1, (i == 0) ? 1 : 0, 0, 0, 0, 0, 0);
      if (i == 2) check_const("imp_not_primed", 0, 0);
      if (i == 3) check_const("imp_first", 2, 1);
      if (i == 6) check_const("imp_last", 5, 1);
    end
    step("imp", 1, 0, 0, 0, 0, 0, 0);
    check_const("imp_tail", 0, 1);

    // Stall: gaps every other cycle
    step("flush", 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step("stall", 1, (i == 0) ? 1 : 0, 0, 0, 0, 0, 0);
      if (i == 4) check_const("stall_after_adv", 3, 1);
      step("gap", 0, 0, 0, 0, 0, 0, 0);
      if (i == 4) check_const("stall_hold", 3, 0);
    end

    // Flush mid-stream, weights retained
    for (int i = 0; i < 6; i++) step("pre_flush", 1, i + 1, 0, 0, 0, 0, 0);
    step("flush_mid", 1, 9, 0, 0, 0, 1, 0);
    check_const("flush_clears", 0, 0);
    for (int i = 0; i < 5; i++) begin
      step("imp2", 1, (i == 0) ? 1 : 0, 0, 0, 0, 0, 0);
      if (i == 4) check_const("imp2_second", 3, 1);
    end

    // Bias path with zero weights
    load_w(0, 0, 0, 0);
    step("flush", 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step("bias", 1, 7, 100 + i, 0, 0, 0, 0);
      if (i == 3) check_const("bias_first", 100, 1);
    end

    // Overflow
    load_w(127, 127, 127, 127);
    step("flush", 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step("ovf", 1, 127, 0, 0, 0, 0, 0);
`ifdef SYSTOLIC_SAT_EN
    check_const("ovf_steady", 16'sd32767, 1);
`else
    check_const("ovf_steady", -16'sd1020, 1);
`endif

    // Reset mid-stream clears weights
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 5, 0, 0, 0, 0, 0);
    step("rst_mid", 1, 5, 0, 1, 9, 1, 1);
    for (int i = 0; i < 5; i++) step("post_rst", 1, 50, 0, 0, 0, 0, 0);
    check_const("rst_zero_w", 0, 1);

    // Reload while streaming
    load_w(3, 3, 3, 3);
    step("flush", 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("reload", 1, 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step("reload_run", 1, 1, 0, 0, 0, 0, 0);
    check_const("reload_steady", 4, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step("rand",
           $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 4000)) - 2000,
           $urandom_range(0, 5) == 0,
           int'($urandom_range(0, 255)) - 128,
           r < 3,
           r == 99);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
